// File: rtl/i2c_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter_if
//
// Purpose: groups the requester-side handshake and the single I2C master
// connection of i2c_bus_arbiter into one bundle.
//
// Signals:
//   req         NREQ    per-requester request, held until that requester's done
//   req_addr    7*NREQ  flattened slave addresses, requester i at [7i+6:7i]
//   req_data    8*NREQ  flattened write bytes, requester i at [8i+7:8i]
//   req_rw      NREQ    per-requester direction (1 = read, 0 = write)
//   gnt         NREQ    one-hot grant, held for the whole transaction
//   done        NREQ    one-hot, one-cycle completion pulse
//   err         1       timeout abort pulse, coincident with done
//   rdata       8       last read byte
//   busy        1       arbiter not idle
//   m_enable    1       to master enable
//   m_addr      7       to master addr
//   m_data      8       to master data_in
//   m_rw        1       to master rw
//   m_ready     1       from master ready
//   m_data_out  8       from master data_out
//
// Modports:
//   slave  - the arbiter's view (serves requests, drives the master)
//   master - the environment's view (requesters plus the I2C master)
// ---------------------------------------------------------------------------
interface i2c_bus_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_rw;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [7:0]        rdata;
  logic              busy;
  logic              m_enable;
  logic [6:0]        m_addr;
  logic [7:0]        m_data;
  logic              m_rw;
  logic              m_ready;
  logic [7:0]        m_data_out;

  modport slave (
    input  req, req_addr, req_data, req_rw, m_ready, m_data_out,
    output gnt, done, err, rdata, busy, m_enable, m_addr, m_data, m_rw
  );

  modport master (
    output req, req_addr, req_data, req_rw, m_ready, m_data_out,
    input  gnt, done, err, rdata, busy, m_enable, m_addr, m_data, m_rw
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
//
// Purpose: round-robin arbiter sharing one I2C master between NREQ
// requesters. The winning request is latched, presented to the master
// (enable/addr/data/rw), followed through the master's ready handshake,
// and completed with a one-cycle done pulse (plus read data) to the
// granted requester. All outputs are registered.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   TIMEOUT  clk cycles allowed per transaction before abort
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   i2c_bus_arbiter_if.slave (requester handshake + master link)
//
// Build option:
//   I2C_ARB_TIMEOUT_EN - when defined, a cycle counter aborts a transaction
//   that spends TIMEOUT cycles in ISSUE+WAIT, pulsing done and err together.
//   When undefined there is no counter, err is constant 0 and the arbiter
//   waits on the master indefinitely.
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_bus_arbiter_if.slave     bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              m_enable_q, m_enable_d;
  logic [6:0]        m_addr_q, m_addr_d;
  logic [7:0]        m_data_q, m_data_d;
  logic              m_rw_q, m_rw_d;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  // Per-requester views of the flattened address/data buses.
  logic [6:0] addr_arr [NREQ];
  logic [7:0] data_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = bus.req_addr[7*gi +: 7];
      assign data_arr[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

  // Round-robin pick: scan ptr+1, ptr+2, ... (mod NREQ). The last winner
  // is checked last, so a requester that re-asserts immediately is served
  // only after everyone else who is pending.
  logic          found;
  logic [PW-1:0] win_idx;

  always_comb begin
    int            cand;
    logic [PW-1:0] cand_idx;
    found    = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(ptr_q) + k) % NREQ;
      cand_idx = PW'(cand);
      if (!found && bus.req[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    rdata_d    = rdata_q;
    m_enable_d = m_enable_q;
    m_addr_d   = m_addr_q;
    m_data_d   = m_data_q;
    m_rw_d     = m_rw_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // done_q is only set in IDLE right after a timeout abort; the
        // aborted requester still holds req that cycle, so hold off one
        // cycle rather than re-grant a request that is being retired.
        if (found && bus.m_ready && (done_q == '0)) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          ptr_d          = win_idx;
          m_addr_d       = addr_arr[win_idx];
          m_data_d       = data_arr[win_idx];
          m_rw_d         = bus.req_rw[win_idx];
          m_enable_d     = 1'b1;
          state_d        = S_ISSUE;
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_d          = '0;
`endif
        end
      end

      S_ISSUE: begin
        // The master samples enable on its divided clock; ready falling is
        // the only proof it has taken the command.
        if (!bus.m_ready) begin
          m_enable_d = 1'b0;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.m_ready) begin
          if (m_rw_q) begin
            rdata_d = bus.m_data_out;
          end
          done_d  = gnt_q;
          gnt_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef I2C_ARB_TIMEOUT_EN
    if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      cnt_d = cnt_q + CW'(1);
      // Abort overrides any completion seen in the same cycle.
      if (cnt_q == CW'(TIMEOUT - 1)) begin
        m_enable_d = 1'b0;
        rdata_d    = rdata_q;
        done_d     = gnt_q;
        err_d      = 1'b1;
        gnt_d      = '0;
        state_d    = S_IDLE;
      end
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= PW'(NREQ - 1);
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      m_enable_q <= 1'b0;
      m_addr_q   <= '0;
      m_data_q   <= '0;
      m_rw_q     <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      m_enable_q <= m_enable_d;
      m_addr_q   <= m_addr_d;
      m_data_q   <= m_data_d;
      m_rw_q     <= m_rw_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = busy_q;
  assign bus.m_enable = m_enable_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_rw     = m_rw_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 1'b0;
`endif

endmodule
